reg_file: RTL and testbench

// - Architectural register file for the single-cycle 32-bit RISC-V core.
// - Two combinational read ports (RD1/RD2, used for rs1/rs2) and one synchronous

---
 rtl/reg_file_pkg.sv | 12 +
 rtl/reg_file.sv | 54 +++++
 tb/tb_reg_file.sv | 130 +++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared register-file definitions for the RV32 core: default widths and
// typedefs for a register word and a register index.
package reg_file_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

    typedef logic [XLEN-1:0]       reg_word_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, all entries cleared by an asynchronous active-low reset.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = XLEN,
    parameter int unsigned ADDR_WIDTH   = REG_ADDR_W,
    parameter bit          X0_HARDWIRED = 1'b0
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic                  WE3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    localparam int unsigned NUM_ENTRIES = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_ENTRIES];
    logic                  write_ok;

    // With x0 hardwired, writes to index 0 are dropped so the stored value stays 0.
    assign write_ok = WE3 && !(X0_HARDWIRED && (A3 == '0));

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[A3] <= WD3;
        end
    end

    // No write-through bypass: a read of A3 sees the new value only after the edge.
    always_comb begin
        RD1 = regs[A1];
        if (X0_HARDWIRED && (A1 == '0)) begin
            RD1 = '0;
        end
    end

    always_comb begin
        RD2 = regs[A2];
        if (X0_HARDWIRED && (A2 == '0)) begin
            RD2 = '0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: one ordinary-x0 and one hardwired-x0 instance
// share stimulus; expectations come from an array model of the register set.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [4:0]  A1 = '0, A2 = '0, A3 = '0;
    logic [31:0] WD3 = '0;
    logic        WE3 = 1'b0;
    logic [31:0] rd1_n, rd2_n, rd1_h, rd2_h;

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .X0_HARDWIRED(1'b0)) dut_n (
        .clk(clk), .RST(RST), .A1(A1), .A2(A2), .A3(A3),
        .WD3(WD3), .WE3(WE3), .RD1(rd1_n), .RD2(rd2_n)
    );

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .X0_HARDWIRED(1'b1)) dut_h (
        .clk(clk), .RST(RST), .A1(A1), .A2(A2), .A3(A3),
        .WD3(WD3), .WE3(WE3), .RD1(rd1_h), .RD2(rd2_h)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] n1, n2, h1, h2;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model[32];
    int          compared   = 0;
    int          mismatched = 0;

    function automatic logic [31:0] model_read(input bit hard, input logic [4:0] a);
        return (hard && a == 5'd0) ? 32'd0 : model[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Monitor: read ports are sampled mid-cycle, away from the write edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, " RD1"},   rd1_n, e.n1);
            chk({e.tag, " RD2"},   rd2_n, e.n2);
            chk({e.tag, " RD1/x0"}, rd1_h, e.h1);
            chk({e.tag, " RD2/x0"}, rd2_h, e.h2);
        end
    end

    // One cycle of stimulus; reads are checked before the next edge, so any
    // write issued here becomes visible to the following cycle only.
    task automatic cycle(input logic rst, input logic we, input logic [4:0] a3,
                         input logic [31:0] wd, input logic [4:0] a1,
                         input logic [4:0] a2, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        RST = rst; WE3 = we; A3 = a3; WD3 = wd; A1 = a1; A2 = a2;
        if (!rst) begin
            for (int i = 0; i < 32; i++) model[i] = '0;
        end
        e.tag = tag;
        e.n1 = model_read(1'b0, a1);
        e.n2 = model_read(1'b0, a2);
        e.h1 = model_read(1'b1, a1);
        e.h2 = model_read(1'b1, a2);
        exp_q.push_back(e);
        if (rst && we) model[a3] = wd;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
        #1 RST = 1'b0;

        // Reset held: every address reads zero on both ports.
        cycle(1'b0, 1'b1, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd31, "reset_3_31");
        for (int i = 0; i < 32; i++)
            cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), "reset_all");

        // x0 write (ordinary instance stores it, hardwired drops it)
        cycle(1'b1, 1'b1, 5'd0, 32'd15, 5'd0, 5'd0, "x0_wr15");
        cycle(1'b1, 1'b1, 5'd0, 32'd60, 5'd0, 5'd1, "x0_rd15");
        cycle(1'b1, 1'b0, 5'd0, 32'd0,  5'd0, 5'd0, "x0_rd60");

        // write-enable gating
        cycle(1'b1, 1'b1, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd0, "we_set5");
        cycle(1'b1, 1'b0, 5'd5, 32'h1234_5678, 5'd5, 5'd5, "we_off");
        cycle(1'b1, 1'b0, 5'd5, 32'h1234_5678, 5'd5, 5'd5, "we_hold");

        // fill all registers, then dual-read sweep
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'(31 - i), 5'(i), "fill");
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), "dual_read");
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7, "same_addr7");

        // collision: old value before the edge, new value after it
        cycle(1'b1, 1'b1, 5'd9, 32'h0000_DEAD, 5'd9, 5'd9, "collide_old");
        cycle(1'b1, 1'b0, 5'd9, 32'd0, 5'd9, 5'd9, "collide_new");

        // randomized traffic
        for (int i = 0; i < 300; i++)
            cycle(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "random");

        // async reset mid-run; an edge with WE3=1 during reset writes nothing
        cycle(1'b0, 1'b1, 5'd12, 32'hCAFE_F00D, 5'd12, 5'd9, "midrst");
        cycle(1'b0, 1'b1, 5'd12, 32'hCAFE_F00D, 5'd12, 5'd0, "midrst_wr");
        for (int i = 0; i < 32; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), "post_rst");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
